// File: rtl/seven_seg_pkg.sv
// Shared definitions for the hex seven-segment driver and monitor.
// Segment order is A..G, with bit 6 = A and bit 0 = G.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        RUN
    } mon_state_t;

    // Returns {legal, value}. legal is 0 for blank and for unknown patterns.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (SEG_GLYPH[i] == s) r = {1'b1, i[3:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_input_filter.sv
// Synchronizes the asynchronous {seg,dp} lines and accepts a pattern only
// after it has been seen unchanged for STABLE_CYCLES consecutive samples.
module seg_input_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_dp,
    output logic [7:0] pat,
    output logic [6:0] next_seg,
    output logic       accept
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]                  synced;
    logic [7:0]                  cand_q;
    logic [CW-1:0]               cnt_q;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign next_seg = cand_q[7:1];

    // Combinational so the top can register its outputs on the same edge
    // that the accepted pattern updates.
    assign accept = (cnt_q == CNT_MAX) && (cand_q != pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
            pat    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], seg_dp};
            if (synced != cand_q) begin
                cand_q <= synced;
                cnt_q  <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept) pat <= cand_q;
        end
    end

endmodule

// File: rtl/seven_seg_monitor.sv
// Decodes filtered seven-segment patterns back to hex digits and checks the
// up/down counting sequence and per-digit dwell time.
module seven_seg_monitor
    import seven_seg_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int DWELL_NOM     = 100000000,
    parameter int DWELL_TOL     = 1000,
    parameter int CNT_W         = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg,
    input  logic             dp,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             blank,
    output logic             dp_state,
    output logic             new_digit,
    output logic             dir_up,
    output logic [CNT_W-1:0] dwell,
    output logic             seg_err,
    output logic             step_err,
    output logic             timing_err,
    output logic [7:0]       step_err_cnt,
    output logic [7:0]       timing_err_cnt
);

    localparam logic [CNT_W-1:0] DWELL_LO = CNT_W'(DWELL_NOM - DWELL_TOL);
    localparam logic [CNT_W-1:0] DWELL_HI = CNT_W'(DWELL_NOM + DWELL_TOL);

    logic [7:0]       pat;
    logic [6:0]       next_seg;
    logic             accept;
    logic             seg_ev;
    logic             dec_valid;
    logic [3:0]       dec_digit;
    logic             is_blank;
    logic             step_up;
    logic             step_dn;
    logic             out_of_tol;
    logic             do_step;
    logic             do_dwell;
    logic             seg_err_d;
    logic             step_bad;
    logic             tim_bad;
    logic [CNT_W-1:0] cnt_q;
    mon_state_t       state_q;
    mon_state_t       state_d;

    seg_input_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .seg_dp  ({seg, dp}),
        .pat     (pat),
        .next_seg(next_seg),
        .accept  (accept)
    );

    // A dp-only change still strobes new_digit but is not a segment event.
    assign seg_ev   = accept && (next_seg != pat[7:1]);
    assign {dec_valid, dec_digit} = seg_decode(next_seg);
    assign is_blank = (next_seg == SEG_BLANK);
    assign dp_state = pat[0];

    assign step_up    = ({1'b0, dec_digit} == {1'b0, digit} + 5'd1);
    assign step_dn    = ({1'b0, digit} == {1'b0, dec_digit} + 5'd1);
    assign out_of_tol = (cnt_q < DWELL_LO) || (cnt_q > DWELL_HI) || (cnt_q == '1);
    assign step_bad   = do_step && !step_up && !step_dn;
    assign tim_bad    = do_dwell && out_of_tol;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_step   = 1'b0;
        do_dwell  = 1'b0;
        seg_err_d = 1'b0;
        if (seg_ev) begin
            case (state_q)
                IDLE: begin
                    if (dec_valid)      state_d = FIRST;
                    else if (!is_blank) seg_err_d = 1'b1;
                end
                FIRST, RUN: begin
                    if (dec_valid) begin
                        do_step  = 1'b1;
                        do_dwell = (state_q == RUN);
                        state_d  = RUN;
                    end else begin
                        seg_err_d = !is_blank;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            dwell          <= '0;
            digit          <= '0;
            digit_valid    <= 1'b0;
            blank          <= 1'b0;
            new_digit      <= 1'b0;
            dir_up         <= 1'b0;
            seg_err        <= 1'b0;
            step_err       <= 1'b0;
            timing_err     <= 1'b0;
            step_err_cnt   <= '0;
            timing_err_cnt <= '0;
        end else begin
            new_digit  <= accept;
            seg_err    <= seg_err_d;
            step_err   <= step_bad;
            timing_err <= tim_bad;

            if (seg_ev)             cnt_q <= CNT_W'(1);
            else if (cnt_q != '1)   cnt_q <= cnt_q + 1'b1;

            if (seg_ev) begin
                dwell       <= cnt_q;
                digit_valid <= dec_valid;
                blank       <= is_blank;
                if (dec_valid) begin
                    digit <= dec_digit;
                    if (do_step && step_up)      dir_up <= 1'b1;
                    else if (do_step && step_dn) dir_up <= 1'b0;
                end
            end

            if (step_bad && step_err_cnt != 8'hFF)  step_err_cnt   <= step_err_cnt + 8'd1;
            if (tim_bad && timing_err_cnt != 8'hFF) timing_err_cnt <= timing_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_seven_seg_monitor.sv
// Bench for seven_seg_monitor: every-cycle comparison against a run-length
// reference model, plus table vectors and hand-written corner sequences.
module tb_seven_seg_monitor;

    localparam int S    = 2;
    localparam int SC   = 4;
    localparam int NOM  = 20;
    localparam int TOL  = 2;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
    localparam logic [6:0] BLANK = 7'b0000000;
    localparam logic [6:0] BAD   = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg = '0;
    logic          dp  = 1'b0;
    logic [3:0]    digit;
    logic          digit_valid, blank, dp_state, new_digit, dir_up;
    logic [CW-1:0] dwell;
    logic          seg_err, step_err, timing_err;
    logic [7:0]    step_err_cnt, timing_err_cnt;

    seven_seg_monitor #(
        .SYNC_STAGES  (S),
        .STABLE_CYCLES(SC),
        .DWELL_NOM    (NOM),
        .DWELL_TOL    (TOL),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .seg           (seg),
        .dp            (dp),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .blank         (blank),
        .dp_state      (dp_state),
        .new_digit     (new_digit),
        .dir_up        (dir_up),
        .dwell         (dwell),
        .seg_err       (seg_err),
        .step_err      (step_err),
        .timing_err    (timing_err),
        .step_err_cnt  (step_err_cnt),
        .timing_err_cnt(timing_err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_new = 0, n_seg = 0, n_step = 0, n_tim = 0;

    // Reference model state
    logic [7:0] pipe [$];
    logic [7:0] hist [$];
    logic [7:0] m_acc;
    int         edge_no = 0;
    int         m_base, streak;
    int         m_digit, m_dwell, m_step_cnt, m_tim_cnt;
    logic       m_valid, m_blank, m_dp, m_new, m_dir;
    logic       m_seg_err, m_step_err, m_tim_err;

    function automatic int glyph_idx(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (GLYPH[i] == s) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] f_in, v;
        bit ok;
        int idx, dw;
        edge_no++;
        m_new = 0; m_seg_err = 0; m_step_err = 0; m_tim_err = 0;
        if (rst) begin
            m_digit = 0; m_valid = 0; m_blank = 0; m_dp = 0; m_dir = 0;
            m_dwell = 0; m_step_cnt = 0; m_tim_cnt = 0;
            m_acc = '0; streak = 0; m_base = edge_no + 1;
            pipe.delete();
            repeat (S) pipe.push_back(8'h00);
            hist.delete();
        end else begin
            f_in = pipe.pop_front();
            pipe.push_back({seg, dp});
            // accept when the last SC filtered samples agree and differ from the accepted one
            ok = (hist.size() == SC);
            foreach (hist[i]) if (hist[i] != hist[0]) ok = 0;
            if (ok && hist[0] == m_acc) ok = 0;
            if (ok) begin
                v = hist[0];
                m_new = 1;
                m_dp = v[0];
                if (v[7:1] != m_acc[7:1]) begin
                    dw = edge_no - m_base;
                    if (dw > CMAX) dw = CMAX;
                    m_dwell = dw;
                    m_base = edge_no;
                    idx = glyph_idx(v[7:1]);
                    m_valid = (idx >= 0);
                    m_blank = (v[7:1] == BLANK);
                    if (idx >= 0) begin
                        if (streak >= 1) begin
                            if (idx == m_digit + 1)      m_dir = 1;
                            else if (idx == m_digit - 1) m_dir = 0;
                            else                         m_step_err = 1;
                        end
                        if (streak >= 2 && (dw < NOM - TOL || dw > NOM + TOL || dw == CMAX))
                            m_tim_err = 1;
                        m_digit = idx;
                        if (streak < 2) streak++;
                    end else begin
                        m_seg_err = !m_blank;
                        streak = 0;
                    end
                    if (m_step_err && m_step_cnt < 255) m_step_cnt++;
                    if (m_tim_err && m_tim_cnt < 255) m_tim_cnt++;
                end
                m_acc = v;
            end
            hist.push_back(f_in);
            if (hist.size() > SC) void'(hist.pop_front());
        end
    endtask

    task automatic cmp_model();
        logic [35:0] act, exp;
        act = {digit, digit_valid, blank, dp_state, new_digit, dir_up, dwell,
               seg_err, step_err, timing_err, step_err_cnt, timing_err_cnt};
        exp = {m_digit[3:0], m_valid, m_blank, m_dp, m_new, m_dir, m_dwell[CW-1:0],
               m_seg_err, m_step_err, m_tim_err, m_step_cnt[7:0], m_tim_cnt[7:0]};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model_cycle edge=%0d actual=%h expected=%h", edge_no, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (new_digit)  n_new++;
        if (seg_err)    n_seg++;
        if (step_err)   n_step++;
        if (timing_err) n_tim++;
        cmp_model();
    endtask

    task automatic show(input logic [6:0] s, input logic d, input int n);
        seg = s;
        dp  = d;
        repeat (n) tick();
    endtask

    typedef struct {
        logic [6:0] s;
        logic       d;
        int         e_digit;
        int         e_valid;
        int         e_blank;
    } vec_t;

    vec_t vt [8];
    int   k, found, n0, s0, t0, m0, sel, hold, cur;
    logic [6:0] ns;
    logic       nd;

    initial begin
        vt[0] = '{GLYPH[4],  1'b0, 4,  1, 0};
        vt[1] = '{GLYPH[5],  1'b1, 5,  1, 0};
        vt[2] = '{GLYPH[11], 1'b0, 11, 1, 0};
        vt[3] = '{BLANK,     1'b0, 11, 0, 1};
        vt[4] = '{7'b1010101, 1'b0, 11, 0, 0};
        vt[5] = '{GLYPH[15], 1'b0, 15, 1, 0};
        vt[6] = '{GLYPH[10], 1'b1, 10, 1, 0};
        vt[7] = '{GLYPH[13], 1'b0, 13, 1, 0};

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_digit", int'(digit), 0);
        chk("reset_blank", int'(blank), 0);
        chk("reset_new", int'(new_digit), 0);
        rst = 1'b0;

        // First glyph after blank: latency and decode
        show(BLANK, 1'b0, 10);
        seg = GLYPH[0];
        k = 0; found = 0;
        while (!found && k < 30) begin
            tick();
            k++;
            if (new_digit) found = 1;
        end
        chk("first_latency", found ? k - 1 : -1, S + SC);
        chk("first_digit", int'(digit), 0);
        chk("first_valid", int'(digit_valid), 1);
        chk("first_no_seg_err", n_seg, 0);
        repeat (20 - k) tick();

        // Up-count at nominal dwell
        show(GLYPH[1], 1'b0, 20);
        show(GLYPH[2], 1'b0, 20);
        chk("up_dwell_2", int'(dwell), 20);
        show(GLYPH[3], 1'b0, 20);
        chk("up_dwell_3", int'(dwell), 20);
        chk("up_dir", int'(dir_up), 1);
        chk("up_step_cnt", int'(step_err_cnt), 0);
        chk("up_tim_cnt", int'(timing_err_cnt), 0);

        // Down-count, then a long dwell
        show(BLANK, 1'b0, 20);
        t0 = n_tim;
        show(GLYPH[15], 1'b0, 20);
        show(GLYPH[14], 1'b0, 25);
        chk("down_dir", int'(dir_up), 0);
        show(GLYPH[13], 1'b0, 20);
        chk("long_dwell", int'(dwell), 25);
        chk("long_tim_pulses", n_tim - t0, 1);
        chk("long_tim_cnt", int'(timing_err_cnt), 1);

        // Skipped step
        show(BLANK, 1'b0, 20);
        s0 = n_step;
        show(GLYPH[3], 1'b0, 20);
        show(GLYPH[6], 1'b0, 20);
        chk("skip_pulses", n_step - s0, 1);
        chk("skip_dir_held", int'(dir_up), 0);
        chk("skip_cnt", int'(step_err_cnt), 1);

        // Short glitch, then a held illegal pattern
        show(BLANK, 1'b0, 20);
        show(GLYPH[5], 1'b0, 20);
        n0 = n_new;
        show(BAD, 1'b0, 3);
        show(GLYPH[5], 1'b0, 20);
        chk("glitch_no_event", n_new - n0, 0);
        m0 = n_seg; s0 = n_step; t0 = n_tim;
        show(BAD, 1'b0, 20);
        chk("illegal_seg_err", n_seg - m0, 1);
        chk("illegal_valid", int'(digit_valid), 0);
        chk("illegal_digit_held", int'(digit), 5);
        show(GLYPH[9], 1'b0, 20);
        chk("after_illegal_no_step", n_step - s0, 0);
        chk("after_illegal_no_tim", n_tim - t0, 0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            show(vt[i].s, vt[i].d, 25);
            chk($sformatf("vec%0d_digit", i), int'(digit), vt[i].e_digit);
            chk($sformatf("vec%0d_valid", i), int'(digit_valid), vt[i].e_valid);
            chk($sformatf("vec%0d_blank", i), int'(blank), vt[i].e_blank);
            chk($sformatf("vec%0d_dp", i), int'(dp_state), int'(vt[i].d));
        end

        // dp-only change
        n0 = n_new; s0 = n_step; t0 = n_tim;
        show(GLYPH[13], 1'b1, 20);
        chk("dp_only_event", n_new - n0, 1);
        chk("dp_only_state", int'(dp_state), 1);
        chk("dp_only_no_checks", (n_step - s0) + (n_tim - t0), 0);

        // Reset in the middle of a dwell
        show(GLYPH[4], 1'b0, 10);
        rst = 1'b1;
        tick();
        chk("midrst_a", int'({digit, digit_valid, blank, dp_state, new_digit, dir_up}), 0);
        chk("midrst_b", int'({dwell, seg_err, step_err, timing_err}), 0);
        chk("midrst_c", int'({step_err_cnt, timing_err_cnt}), 0);
        rst = 1'b0;

        // Dwell counter saturation
        show(BLANK, 1'b0, 20);
        show(GLYPH[1], 1'b0, 20);
        show(GLYPH[2], 1'b0, 300);
        t0 = n_tim;
        show(GLYPH[3], 1'b0, 20);
        chk("sat_dwell", int'(dwell), CMAX);
        chk("sat_tim_pulse", n_tim - t0, 1);

        // Error counter saturation
        s0 = n_step;
        for (int i = 0; i < 300; i++) show((i % 2 == 0) ? GLYPH[6] : GLYPH[3], 1'b0, 8);
        chk("step_pulses_300", n_step - s0, 300);
        chk("step_cnt_sat", int'(step_err_cnt), 255);
        chk("tim_cnt_sat", int'(timing_err_cnt), 255);

        // Randomized traffic checked cycle by cycle against the model
        cur = 3;
        for (int r = 0; r < 400; r++) begin
            sel  = $urandom_range(0, 99);
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : $urandom_range(15, 30);
            ns = seg;
            nd = dp;
            if (sel < 55) begin
                cur = ($urandom_range(0, 1) == 1) ? cur + 1 : cur - 1;
                cur = cur & 15;
                ns = GLYPH[cur];
            end else if (sel < 65) begin
                cur = $urandom_range(0, 15);
                ns = GLYPH[cur];
            end else if (sel < 75) begin
                ns = BLANK;
            end else if (sel < 85) begin
                ns = 7'($urandom_range(0, 127));
            end else if (sel < 97) begin
                nd = ~dp;
            end else begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            show(ns, nd, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
